capture_ctrl: RTL

- Sequences one acquisition of the logic-analyzer/scope capture path: paces sampling by decimation, fills the pre-trigger region of the circular sample RAM, then arms the per-channel trigger logic.
- Combines the per-channel trigger outputs, counts post-trigger samples, and signals completion.
- Sits between the command/config register file and the channel trigger logic plus sample RAM write port.

---
 rtl/capture_pkg.sv | 21 ++
 rtl/capture_ctrl_prescaler.sv | 27 ++
 rtl/capture_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// Shared types and defaults for the capture sequencer.
package capture_pkg;

  localparam int ENTRIES_DEF = 384;
  localparam int AW_DEF      = 9;
  localparam int NUM_CH_DEF  = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREFILL = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    DONE    = 3'd4
  } capture_state_t;

  // Trigger position cannot exceed the last RAM slot.
  function automatic int clamp_tp(input int trig_pos, input int entries);
    return (trig_pos > entries - 1) ? entries - 1 : trig_pos;
  endfunction

endpackage

// File: rtl/capture_ctrl_prescaler.sv
// Sample-rate divider: smpl_en pulses once every 2**decimator clocks,
// first pulse 2**decimator cycles after clr.
module smpl_prescaler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [3:0] decimator,
  output logic       smpl_en
);

  logic [15:0] r_cnt;
  logic [15:0] w_limit;

  assign w_limit = (16'd1 << decimator) - 16'd1;
  assign smpl_en = (r_cnt == w_limit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || smpl_en) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Acquisition sequencer: paced pre-trigger fill of the circular sample RAM,
// trigger combine, post-trigger count and completion handshake.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int AW      = AW_DEF,
  parameter int NUM_CH  = NUM_CH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              abort,
  input  logic              clr_done,
  input  logic [3:0]        decimator,
  input  logic [AW-1:0]     trig_pos,
  input  logic [NUM_CH-1:0] chx_trig,
  output logic              armed,
  output logic              we,
  output logic [AW-1:0]     waddr,
  output logic [AW-1:0]     trig_addr,
  output logic              triggered,
  output logic              capture_done
);

  localparam logic [AW:0]   L_ENTRIES = (AW+1)'(ENTRIES);
  localparam logic [AW-1:0] L_LAST    = AW'(ENTRIES - 1);

  capture_state_t r_state;
  capture_state_t w_next;

  logic [AW-1:0] r_waddr;
  logic [AW:0]   r_smpl_cnt;
  logic [AW-1:0] r_post_cnt;
  logic [AW-1:0] r_tp;
  logic [3:0]    r_dec;
  logic          r_armed;
  logic          r_triggered;
  logic [AW-1:0] r_trig_addr;
  logic          r_done;

  logic          w_smpl_en;
  logic          w_start;
  logic          w_abort;
  logic          w_trig;
  logic          w_write;
  logic [AW-1:0] w_waddr_inc;
  logic [AW:0]   w_prefill_target;

  assign w_start          = (r_state == IDLE) && run && !abort && !clr_done;
  assign w_abort          = abort && (r_state != IDLE);
  assign w_waddr_inc      = (r_waddr == L_LAST) ? '0 : r_waddr + 1'b1;
  assign w_prefill_target = L_ENTRIES - {1'b0, r_tp};

  smpl_prescaler u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (w_start),
    .decimator (r_dec),
    .smpl_en   (w_smpl_en)
  );

  always_comb begin
    w_next  = r_state;
    w_write = 1'b0;
    w_trig  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) w_next = PREFILL;
      end
      PREFILL: begin
        w_write = w_smpl_en;
        if (w_write && (r_smpl_cnt + 1'b1 == w_prefill_target)) w_next = ARMED;
      end
      ARMED: begin
        w_trig  = r_armed && (&chx_trig) && !w_abort;
        // With no post-trigger region the trigger-cycle sample is not kept.
        w_write = w_smpl_en && !(w_trig && (r_tp == '0));
        if (w_trig) begin
          if ((r_tp == '0) || (w_write && (r_tp == AW'(1)))) w_next = DONE;
          else                                               w_next = POST;
        end
      end
      POST: begin
        w_write = w_smpl_en;
        if (w_write && (r_post_cnt + 1'b1 == r_tp)) w_next = DONE;
      end
      DONE: begin
        if (clr_done) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_waddr     <= '0;
      r_smpl_cnt  <= '0;
      r_post_cnt  <= '0;
      r_tp        <= '0;
      r_dec       <= '0;
      r_armed     <= 1'b0;
      r_triggered <= 1'b0;
      r_trig_addr <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_armed <= (w_next == ARMED) || (w_next == POST);
      r_done  <= (w_next == DONE);

      if (w_start) begin
        r_waddr    <= '0;
        r_smpl_cnt <= '0;
        r_post_cnt <= '0;
        r_tp       <= AW'(clamp_tp(int'(trig_pos), ENTRIES));
        r_dec      <= decimator;
      end else if (w_write) begin
        r_waddr <= w_waddr_inc;
        if (r_state == PREFILL) r_smpl_cnt <= r_smpl_cnt + 1'b1;
        if ((r_state == POST) || w_trig) r_post_cnt <= r_post_cnt + 1'b1;
      end

      if (w_trig) r_trig_addr <= r_waddr;

      if (w_next == IDLE)  r_triggered <= 1'b0;
      else if (w_trig)     r_triggered <= 1'b1;
    end
  end

  assign armed        = r_armed;
  assign we           = w_write;
  assign waddr        = r_waddr;
  assign trig_addr    = r_trig_addr;
  assign triggered    = r_triggered;
  assign capture_done = r_done;

endmodule
